// File: rtl/zica_pkg.sv
// rtl/zica_pkg.sv - shared constants and FSM state type for the Z-pair streamer
package zica_pkg;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_M          = 1024;
    localparam int DEF_N          = 7;
    localparam int DEF_ADDR_WIDTH = $clog2(DEF_M * DEF_N);
    localparam int DEF_CH_WIDTH   = $clog2(DEF_N);
    localparam int DEF_IDX_WIDTH  = $clog2(DEF_M);
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;
endpackage

// File: rtl/zpair_fifo.sv
// rtl/zpair_fifo.sv - first-word-fall-through skid FIFO with empty bypass and count
module zpair_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             empty;
    logic             accept;
    logic             store;
    logic             drain;

    // An empty FIFO presents the incoming word directly so a full-rate stream sees no bubble.
    always_comb begin
        empty  = (count == '0);
        valid  = !empty || push;
        accept = pop && valid;
        store  = push && !(empty && accept);
        drain  = accept && !empty;
        dout   = '0;
        if (!empty) begin
            dout = mem[rd_ptr];
        end else if (push) begin
            dout = din;
        end
    end

    // Pointer and occupancy bookkeeping; overflow can only come from a broken credit rule.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            assert (!(store && !drain && count == CW'(DEPTH)));
            if (store) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (drain) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(store) - CW'(drain);
        end
    end

    // Storage array needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_ptr] <= din;
        end
    end
endmodule

// File: rtl/zpair_streamer.sv
// rtl/zpair_streamer.sv - sweeps one channel pair of Z memory and streams (z_p, z_q) pairs
module zpair_streamer
    import zica_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int M          = DEF_M,
    parameter int N          = DEF_N,
    parameter int CH_WIDTH   = DEF_CH_WIDTH,
    parameter int IDX_WIDTH  = DEF_IDX_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CH_WIDTH-1:0]   ch_p,
    input  logic [CH_WIDTH-1:0]   ch_q,
    output logic                  mem_readEn,
    output logic [ADDR_WIDTH-1:0] mem_addr1,
    output logic [ADDR_WIDTH-1:0] mem_addr2,
    input  logic [DATA_WIDTH-1:0] mem_dout1,
    input  logic [DATA_WIDTH-1:0] mem_dout2,
    input  logic                  mem_dout_valid,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_zp,
    output logic [DATA_WIDTH-1:0] out_zq,
    output logic [IDX_WIDTH-1:0]  out_idx,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int FW = 2 * DATA_WIDTH + IDX_WIDTH + 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t                state;
    state_t                state_nx;
    logic [IDX_WIDTH-1:0]  k_issue;
    logic [IDX_WIDTH-1:0]  k_recv;
    logic [ADDR_WIDTH-1:0] base_p;
    logic [ADDR_WIDTH-1:0] base_q;
    logic                  inflight;
    logic                  err_q;
    logic                  legal_cmd;
    logic                  accept_cmd;
    logic                  issue;
    logic                  push;
    logic [FW-1:0]         push_data;
    logic [FW-1:0]         head_data;
    logic [CW-1:0]         fifo_count;

    // Command legality, read credit and capture of returning read data.
    always_comb begin
        legal_cmd  = (ch_p != ch_q) && (32'(ch_p) < N) && (32'(ch_q) < N);
        accept_cmd = (state == IDLE) && start && legal_cmd;
        issue      = (state == ISSUE) &&
                     ((32'(fifo_count) + 32'(inflight)) < 32'(FIFO_DEPTH));
        push       = mem_dout_valid && (state != IDLE);
        push_data  = {mem_dout1, mem_dout2, k_recv, (k_recv == IDX_WIDTH'(M - 1))};
        mem_readEn = issue;
        mem_addr1  = issue ? base_p : '0;
        mem_addr2  = issue ? base_q : '0;
        err        = err_q;
    end

    // Sweep FSM: issue reads under credit, then drain until the last pair has left.
    always_comb begin
        state_nx = state;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (accept_cmd) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (issue && (k_issue == IDX_WIDTH'(M - 1))) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (!inflight && (fifo_count == '0)) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        busy = (state != IDLE) && !done;
    end

    // State, sample counters and running address bases (addr = k*N + ch built by adding N).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            k_issue  <= '0;
            k_recv   <= '0;
            base_p   <= '0;
            base_q   <= '0;
            inflight <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            inflight <= issue;
            err_q    <= (state == IDLE) && start && !legal_cmd;
            if (accept_cmd) begin
                k_issue <= '0;
                k_recv  <= '0;
                base_p  <= ADDR_WIDTH'(ch_p);
                base_q  <= ADDR_WIDTH'(ch_q);
            end else begin
                if (issue) begin
                    k_issue <= k_issue + IDX_WIDTH'(1);
                    base_p  <= base_p + ADDR_WIDTH'(N);
                    base_q  <= base_q + ADDR_WIDTH'(N);
                end
                if (push) begin
                    k_recv <= k_recv + IDX_WIDTH'(1);
                end
            end
        end
    end

    zpair_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_data),
        .pop   (out_ready),
        .valid (out_valid),
        .dout  (head_data),
        .count (fifo_count)
    );

    // Unpack the head entry onto the stream fields.
    always_comb begin
        {out_zp, out_zq, out_idx, out_last} = head_data;
    end
endmodule

// File: tb/tb_zpair_streamer.sv
// tb/tb_zpair_streamer.sv - randomized self-checking bench for zpair_streamer
module tb_zpair_streamer;
    import zica_pkg::*;

    localparam int DW = DEF_DATA_WIDTH;
    localparam int AW = DEF_ADDR_WIDTH;
    localparam int CH = DEF_CH_WIDTH;
    localparam int IW = DEF_IDX_WIDTH;
    localparam int MM = DEF_M;
    localparam int NN = DEF_N;
    localparam int FD = DEF_FIFO_DEPTH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CH-1:0] ch_p = '0;
    logic [CH-1:0] ch_q = '0;
    logic          mem_readEn;
    logic [AW-1:0] mem_addr1;
    logic [AW-1:0] mem_addr2;
    logic [DW-1:0] mem_dout1;
    logic [DW-1:0] mem_dout2;
    logic          mem_dout_valid;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_zp;
    logic [DW-1:0] out_zq;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          err;

    zpair_streamer dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .ch_p           (ch_p),
        .ch_q           (ch_q),
        .mem_readEn     (mem_readEn),
        .mem_addr1      (mem_addr1),
        .mem_addr2      (mem_addr2),
        .mem_dout1      (mem_dout1),
        .mem_dout2      (mem_dout2),
        .mem_dout_valid (mem_dout_valid),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_zp         (out_zp),
        .out_zq         (out_zq),
        .out_idx        (out_idx),
        .out_last       (out_last),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Z memory with one-cycle registered read
    logic [DW-1:0] zmem [1 << AW];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_dout_valid <= 1'b0;
            mem_dout1      <= '0;
            mem_dout2      <= '0;
        end else begin
            mem_dout_valid <= mem_readEn;
            if (mem_readEn) begin
                mem_dout1 <= zmem[mem_addr1];
                mem_dout2 <= zmem[mem_addr2];
            end
        end
    end

    // 0: always ready, 1: ready 30% of cycles, 2: held low
    int rdy_mode = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(99) < 30);
            default: out_ready = 1'b0;
        endcase
    end

    // Reference: expected pair stream of one sweep, in order
    logic [63:0] exp_q[$];
    int start_cyc = 0;
    int first_valid_cyc = -1;
    int iss_cnt = 0;
    int acc_cnt = 0;

    task automatic load_exp(input int p, input int q);
        for (int k = 0; k < MM; k++) begin
            exp_q.push_back(64'({zmem[k * NN + p], zmem[k * NN + q], IW'(k), (k == MM - 1)}));
        end
    endtask

    logic [63:0] obs;
    assign obs = 64'({out_zp, out_zq, out_idx, out_last});

    bit          stalled_prev = 0;
    logic [63:0] held = '0;

    always @(negedge clk) begin
        if (rst) begin
            stalled_prev = 0;
        end else begin
            if (stalled_prev) check("stable", {out_valid, obs}, {1'b1, held});
            if (mem_readEn) check("credit", ((iss_cnt - acc_cnt) < FD), 1);
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("extra_pair", obs, 128'hdead);
                else check("pair", obs, exp_q.pop_front());
                acc_cnt++;
            end
            if (mem_readEn) iss_cnt++;
            stalled_prev = out_valid && !out_ready;
            held = obs;
        end
    end

    task automatic do_start(input int p, input int q, input bit expect_sweep);
        @(posedge clk);
        #1;
        start = 1'b1;
        ch_p  = CH'(p);
        ch_q  = CH'(q);
        if (expect_sweep) begin
            start_cyc = cyc;
            first_valid_cyc = -1;
            load_exp(p, q);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        int n = 0;
        dcyc = -1;
        while (n < budget) begin
            @(negedge clk);
            if (done) begin
                dcyc = cyc;
                break;
            end
            n++;
        end
        if (dcyc < 0) check("done_timeout", 0, 1);
        check("busy_at_done", busy, 0);
        check("sweep_complete", exp_q.size(), 0);
    endtask

    task automatic wait_progress(input int k, input int budget);
        int n = 0;
        while ((MM - exp_q.size()) < k && n < budget) begin
            @(negedge clk);
            n++;
        end
        if ((MM - exp_q.size()) < k) check("progress_timeout", 0, 1);
    endtask

    task automatic randomize_mem();
        for (int a = 0; a < (1 << AW); a++) zmem[a] = DW'($urandom);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        int dc;
        int iss0;
        for (int a = 0; a < (1 << AW); a++) zmem[a] = DW'(a);

        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {mem_readEn, out_valid, out_last, busy, done, err}, 0);
        check("reset_data", {mem_addr1, mem_addr2, out_zp, out_zq, out_idx}, 0);
        rst = 1'b0;

        // full-rate sweep, memory value = address
        rdy_mode = 0;
        do_start(2, 5, 1);
        check("busy_running", busy, 1);
        wait_done(3000, dc);
        check("done_cycle", dc - start_cyc, MM + 2);
        check("first_valid", first_valid_cyc - start_cyc, 2);
        @(negedge clk);
        check("done_pulse", done, 0);

        // backpressure with a long hold-low window
        randomize_mem();
        rdy_mode = 1;
        do_start(1, 3, 1);
        wait_progress(300, 5000);
        rdy_mode = 2;
        repeat (50) @(negedge clk);
        check("hold_readEn", mem_readEn, 0);
        check("hold_valid", out_valid, 1);
        rdy_mode = 1;
        wait_done(12000, dc);

        // illegal commands
        rdy_mode = 0;
        iss0 = iss_cnt;
        do_start(3, 3, 0);
        @(negedge clk);
        check("err_same_ch", {err, busy}, 2'b10);
        @(negedge clk);
        check("err_pulse_end", err, 0);
        do_start(7, 0, 0);
        @(negedge clk);
        check("err_range", {err, busy}, 2'b10);
        @(negedge clk);
        check("err_pulse_end2", err, 0);
        repeat (3) @(negedge clk);
        check("no_read_illegal", iss_cnt - iss0, 0);

        // start while busy is ignored
        randomize_mem();
        rdy_mode = 1;
        do_start(0, 6, 1);
        wait_progress(100, 5000);
        do_start(1, 4, 0);
        @(negedge clk);
        check("busy_kept", {busy, err}, 2'b10);
        wait_done(12000, dc);

        // back-to-back: next start the cycle after done
        rdy_mode = 0;
        randomize_mem();
        do_start(3, 5, 1);
        wait_done(3000, dc);
        check("b2b_done_cycle", dc - start_cyc, MM + 2);

        // reset mid-sweep, then a fresh sweep
        rdy_mode = 1;
        do_start(4, 2, 1);
        wait_progress(500, 8000);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_ctrl", {mem_readEn, out_valid, out_last, busy, done, err}, 0);
        check("rst_mid_data", {mem_addr1, mem_addr2, out_zp, out_zq, out_idx}, 0);
        exp_q.delete();
        iss_cnt = 0;
        acc_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_mode = 0;
        do_start(0, 1, 1);
        wait_done(3000, dc);
        check("post_rst_done_cycle", dc - start_cyc, MM + 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
